// File: rtl/gis_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gis_pkg
//  Purpose  : Shared types and constants for the graphic instruction
//             scheduler: FSM state encoding, CLEAR opcode and the default
//             commit-window scan coordinates.
//  Revision : 1.0 - initial release
// ============================================================================
package gis_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } gis_state_e;

    // The same encoding as explicit-width constants, for FSM registers
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ARMED  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    // Opcode in INS[31:28] that means "clear frame" instead of "store word"
    localparam logic [3:0] c_OPC_CLEAR = 4'hF;

    // Default scan position that opens the commit window
    localparam logic [9:0] c_COMMIT_X_DEF = 10'd634;
    localparam logic [9:0] c_COMMIT_Y_DEF = 10'd479;

endpackage
`default_nettype wire

// File: rtl/gis_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : gis_fifo
//  Purpose  : First-word-fall-through FIFO holding queued CPU instructions.
//             o_dout always shows the oldest entry; o_count is the occupancy.
//             Pushes while full and pops while empty are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module gis_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != c_FULL);
    assign w_do_pop  = i_pop  && (r_count != '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: written on accepted pushes, contents need no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/graphic_instruction_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : graphic_instruction_scheduler
//  Purpose  : Queues CPU graphic instructions and commits them to the
//             instruction memory only inside a scan-position window, so the
//             renderer never sees a half-updated frame. CLEAR entries pulse
//             FRAME_CLR and rewind the write pointer instead of writing.
//  Options  : GIS_DEDUP_EN - drop a word equal to the last pushed word
//             (handshake still completes).
//  Revision : 1.0 - initial release
// ============================================================================
module graphic_instruction_scheduler
    import gis_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter int         ADD_W    = 6,
    parameter logic [9:0] COMMIT_X = c_COMMIT_X_DEF,
    parameter logic [9:0] COMMIT_Y = c_COMMIT_Y_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [9:0]               SYS_X,
    input  logic [9:0]               SYS_Y,
    input  logic [31:0]              INS,
    input  logic                     INS_VALID,
    output logic                     INS_READY,
    output logic                     MEM_WE,
    output logic [ADD_W-1:0]         MEM_ADD,
    output logic [31:0]              MEM_DATA,
    output logic                     FRAME_CLR,
    output logic [$clog2(DEPTH):0]   PENDING,
    output logic                     OVERFLOW
);

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_drain;
    logic [ADD_W-1:0] r_wptr;
    logic [ADD_W-1:0] r_mem_add;
    logic [31:0]      r_mem_data;
    logic             r_overflow;

    logic [c_CW-1:0]  w_count;
    logic [31:0]      w_head;
    logic             w_handshake;
    logic             w_push;
    logic             w_commit;
    logic             w_is_clear;
    logic             w_we;
    logic             w_clr;
    logic             w_trigger;

    // Ready depends only on registered occupancy, so a pop cannot open a slot
    // in the same cycle
    assign w_handshake = INS_VALID && INS_READY;
    assign INS_READY   = (w_count < c_FULL);

`ifdef GIS_DEDUP_EN
    logic [31:0] r_last_word;

    // Remember the last word actually queued to suppress back-to-back repeats
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_word <= 32'h0;
        end else if (w_push) begin
            r_last_word <= INS;
        end
    end

    assign w_push = w_handshake && (INS != r_last_word);
`else
    assign w_push = w_handshake;
`endif

    assign w_commit   = (r_state == c_ST_COMMIT);
    assign w_is_clear = (w_head[31:28] == c_OPC_CLEAR);
    assign w_we       = w_commit && !w_is_clear;
    assign w_clr      = w_commit &&  w_is_clear;
    assign w_trigger  = (SYS_X == COMMIT_X) && (SYS_Y == COMMIT_Y);

    gis_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_push  (w_push),
        .i_din   (INS),
        .i_pop   (w_commit),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    // Outputs show the live pop during COMMIT and hold the last write otherwise
    assign MEM_WE    = w_we;
    assign FRAME_CLR = w_clr;
    assign MEM_ADD   = w_we ? r_wptr : r_mem_add;
    assign MEM_DATA  = w_we ? w_head : r_mem_data;
    assign PENDING   = w_count;
    assign OVERFLOW  = r_overflow;

    // Commit FSM: the drain count is frozen at the trigger so late pushes
    // wait for the next window
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
            r_drain <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_count != '0) begin
                        r_state <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    if (w_trigger && (w_count != '0)) begin
                        r_state <= c_ST_COMMIT;
                        r_drain <= w_count;
                    end
                end
                c_ST_COMMIT: begin
                    r_drain <= r_drain - 1'b1;
                    if (r_drain == c_ONE) begin
                        r_state <= ((w_count > c_ONE) || w_push) ? c_ST_ARMED : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Write pointer and held memory-port values
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wptr     <= '0;
            r_mem_add  <= '0;
            r_mem_data <= 32'h0;
        end else if (w_we) begin
            r_wptr     <= r_wptr + 1'b1;
            r_mem_add  <= r_wptr;
            r_mem_data <= w_head;
        end else if (w_clr) begin
            r_wptr     <= '0;
        end
    end

    // Sticky overflow on any offer the FIFO could not take
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_overflow <= 1'b0;
        end else if (INS_VALID && !INS_READY) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_graphic_instruction_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_graphic_instruction_scheduler
//  Purpose  : Directed self-checking bench for graphic_instruction_scheduler
//             (DEPTH=4, ADD_W=6, default commit window).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_graphic_instruction_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  SYS_X;
    logic [9:0]  SYS_Y;
    logic [31:0] INS;
    logic        INS_VALID;
    logic        INS_READY;
    logic        MEM_WE;
    logic [5:0]  MEM_ADD;
    logic [31:0] MEM_DATA;
    logic        FRAME_CLR;
    logic [2:0]  PENDING;
    logic        OVERFLOW;

    int n_vec = 0;
    int n_err = 0;

    graphic_instruction_scheduler dut (
        .CLK       (CLK),
        .RST       (RST),
        .SYS_X     (SYS_X),
        .SYS_Y     (SYS_Y),
        .INS       (INS),
        .INS_VALID (INS_VALID),
        .INS_READY (INS_READY),
        .MEM_WE    (MEM_WE),
        .MEM_ADD   (MEM_ADD),
        .MEM_DATA  (MEM_DATA),
        .FRAME_CLR (FRAME_CLR),
        .PENDING   (PENDING),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        INS       = w;
        INS_VALID = 1'b1;
        tick();
        INS_VALID = 1'b0;
    endtask

    // One settling cycle, then one cycle with the scan at the commit position
    task automatic trigger();
        tick();
        SYS_X = 10'd634;
        SYS_Y = 10'd479;
        tick();
        SYS_X = 10'd0;
        SYS_Y = 10'd0;
    endtask

    task automatic expect_write(input string tag, input logic [5:0] a, input logic [31:0] d);
        chk({tag, "_we"},   {31'b0, MEM_WE},    32'd1);
        chk({tag, "_add"},  {26'b0, MEM_ADD},   {26'b0, a});
        chk({tag, "_data"}, MEM_DATA,           d);
        chk({tag, "_clr"},  {31'b0, FRAME_CLR}, 32'd0);
        tick();
    endtask

    initial begin
        RST = 1'b0; INS = '0; INS_VALID = 1'b0; SYS_X = '0; SYS_Y = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pending",  {29'b0, PENDING},   32'd0);
        chk("rst_we",       {31'b0, MEM_WE},    32'd0);
        chk("rst_clr",      {31'b0, FRAME_CLR}, 32'd0);
        chk("rst_ovf",      {31'b0, OVERFLOW},  32'd0);
        chk("rst_add",      {26'b0, MEM_ADD},   32'd0);
        chk("rst_data",     MEM_DATA,           32'd0);
        RST = 1'b1;
        tick();
        chk("rst_ready",    {31'b0, INS_READY}, 32'd1);

        // Trigger with nothing queued does nothing
        SYS_X = 10'd634; SYS_Y = 10'd479;
        tick();
        SYS_X = 10'd0;   SYS_Y = 10'd0;
        chk("empty_trig_we", {31'b0, MEM_WE}, 32'd0);

        // Three words committed in order at 0,1,2
        push(32'h1111_0001);
        push(32'h2222_0002);
        push(32'h3333_0003);
        chk("abc_pending", {29'b0, PENDING}, 32'd3);
        trigger();
        expect_write("abc0", 6'd0, 32'h1111_0001);
        expect_write("abc1", 6'd1, 32'h2222_0002);
        expect_write("abc2", 6'd2, 32'h3333_0003);
        chk("abc_done_we",   {31'b0, MEM_WE},  32'd0);
        chk("abc_done_pend", {29'b0, PENDING}, 32'd0);
        chk("abc_hold_data", MEM_DATA,         32'h3333_0003);
        chk("abc_hold_add",  {26'b0, MEM_ADD}, 32'd2);

        // Fifth push while full is dropped and flags overflow
        push(32'h4000_0000);
        push(32'h4000_0001);
        push(32'h4000_0002);
        push(32'h4000_0003);
        chk("full_ready", {31'b0, INS_READY}, 32'd0);
        chk("full_ovf0",  {31'b0, OVERFLOW},  32'd0);
        push(32'h4000_0004);
        chk("full_ovf1",  {31'b0, OVERFLOW},  32'd1);
        chk("full_pend",  {29'b0, PENDING},   32'd4);
        trigger();
        chk("full_ready_commit", {31'b0, INS_READY}, 32'd0);
        expect_write("full0", 6'd3, 32'h4000_0000);
        expect_write("full1", 6'd4, 32'h4000_0001);
        expect_write("full2", 6'd5, 32'h4000_0002);
        expect_write("full3", 6'd6, 32'h4000_0003);
        chk("full_after_pend", {29'b0, PENDING},  32'd0);
        chk("full_after_ovf",  {31'b0, OVERFLOW}, 32'd1);

        // A push during COMMIT waits for the next window
        push(32'h5555_0005);
        trigger();
        INS = 32'h6666_0006; INS_VALID = 1'b1;
        expect_write("late0", 6'd7, 32'h5555_0005);
        INS_VALID = 1'b0;
        chk("late_we",   {31'b0, MEM_WE},  32'd0);
        chk("late_pend", {29'b0, PENDING}, 32'd1);
        trigger();
        expect_write("late1", 6'd8, 32'h6666_0006);

        // CLEAR entry pulses FRAME_CLR and rewinds the pointer
        push(32'h7777_0007);
        push(32'hF000_0000);
        push(32'h8888_0008);
        trigger();
        expect_write("clr0", 6'd9, 32'h7777_0007);
        chk("clr_pulse", {31'b0, FRAME_CLR}, 32'd1);
        chk("clr_we",    {31'b0, MEM_WE},    32'd0);
        tick();
        expect_write("clr1", 6'd0, 32'h8888_0008);
        chk("clr_after", {31'b0, FRAME_CLR}, 32'd0);

        // Advance the pointer from 1 to 63, then wrap
        for (int b = 0; b < 15; b++) begin
            for (int k = 0; k < 4; k++) push(32'h0900_0000 + 32'(b * 4 + k));
            trigger();
            repeat (4) tick();
        end
        push(32'h0A00_0000);
        push(32'h0A00_0001);
        trigger();
        repeat (2) tick();
        chk("adv_add", {26'b0, MEM_ADD}, 32'd62);
        push(32'h0B00_0001);
        push(32'h0B00_0002);
        trigger();
        expect_write("wrap0", 6'd63, 32'h0B00_0001);
        expect_write("wrap1", 6'd0,  32'h0B00_0002);

        // Asynchronous reset in the middle of a commit
        push(32'h0C00_0001);
        push(32'h0C00_0002);
        push(32'h0C00_0003);
        trigger();
        chk("mid_we", {31'b0, MEM_WE}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_we",   {31'b0, MEM_WE},  32'd0);
        chk("mid_rst_pend", {29'b0, PENDING}, 32'd0);
        chk("mid_rst_add",  {26'b0, MEM_ADD}, 32'd0);
        chk("mid_rst_ovf",  {31'b0, OVERFLOW}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, INS_READY}, 32'd1);
        chk("post_rst_we",    {31'b0, MEM_WE},    32'd0);

        // Repeated word: deduplicated only when the option is built in
        push(32'hA5A5_0001);
        push(32'hA5A5_0001);
        push(32'hB6B6_0002);
`ifdef GIS_DEDUP_EN
        chk("dup_pend", {29'b0, PENDING}, 32'd2);
        trigger();
        expect_write("dup0", 6'd0, 32'hA5A5_0001);
        expect_write("dup1", 6'd1, 32'hB6B6_0002);
`else
        chk("dup_pend", {29'b0, PENDING}, 32'd3);
        trigger();
        expect_write("dup0", 6'd0, 32'hA5A5_0001);
        expect_write("dup1", 6'd1, 32'hA5A5_0001);
        expect_write("dup2", 6'd2, 32'hB6B6_0002);
`endif
        chk("dup_done_we", {31'b0, MEM_WE}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
